tone_sequencer: RTL and testbench
=================================

Name: tone_sequencer

Overview:
- Plays a stored two-channel melody by driving the `right_div`/`left_div` inputs of the stereo buzzer, one note at a time, at a fixed tempo.
- Lets a one-shot sound-effect (SFX) request pre-empt the melody.
- Provides a `mute` flag; top level gates buzzer audio to 16'h0000 while `mute`=1.
- Sits between the game/control FSM and the buzzer.

Parameters:
- BEAT_CYCLES, 25_000_000, clk cycles per beat (0.25 s at 100 MHz).
- GAP_CYCLES, 2_500_000, silent articulation gap at the end of each note; must be < BEAT_CYCLES.
- SFX_CYCLES, 10_000_000, SFX tone duration in cycles.
- SFX_DIV, 27'd50_000, divider value on both channels during SFX.
- SONG_LEN, 32, number of ROM entries (index width IDX_W = clog2(SONG_LEN)).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begin playback at entry 0.
- stop  in  1  pulse; abort everything and go idle.
- loop_en  in  1  level; wrap to entry 0 at song end instead of finishing.
- sfx_req  in  1  pulse; request an SFX tone.
- right_div  out  27  divider for the right buzzer channel.
- left_div  out  27  divider for the left buzzer channel.
- mute  out  1  1 = channel output must be silenced.
- busy  out  1  1 in any state except IDLE.
- done  out  1  one-cycle pulse when the song ends without looping.
- sfx_ack  out  1  one-cycle pulse when an SFX completes.
- note_idx  out  IDX_W  current ROM index.

Behaviour:
- Reset (rst=0, async):
  - State IDLE; right_div=left_div=0; mute=1; busy=0; done=0; sfx_ack=0; note_idx=0; cycle counter=0; resume flag=0.
- All outputs are registered.
- ROM entry format: {left_div[26:0], right_div[26:0], beats[3:0]}. beats=0 is the end marker.
- States:
  - IDLE:
    - mute=1, divs=0.
    - start → NOTE at index 0.
  - NOTE:
    - divs = ROM[note_idx]; mute=0.
    - Counter runs 0 .. beats*BEAT_CYCLES-GAP_CYCLES-1.
    - At terminal count → GAP, counter cleared.
  - GAP:
    - divs hold; mute=1.
    - Counter runs GAP_CYCLES cycles, then advance:
      - next = note_idx+1.
      - If note_idx==SONG_LEN-1 or ROM[next].beats==0: with loop_en=1 → NOTE at index 0; with loop_en=0 → IDLE and pulse done.
      - Otherwise → NOTE at next.
  - SFX:
    - divs=SFX_DIV on both channels; mute=0.
    - Runs SFX_CYCLES cycles, then pulses sfx_ack.
    - Returns to NOTE at the saved note_idx with counter 0 (note restarts) if the resume flag is set, else to IDLE.
- Latency: a start sampled in cycle N gives NOTE outputs valid in cycle N+1. Same for sfx_req → SFX outputs.
- Pre-emption:
  - sfx_req in IDLE/NOTE/GAP → SFX.
  - Resume flag = 1 if the state was NOTE or GAP. note_idx is frozen.
  - sfx_req while in SFX is ignored (no extension, no extra ack).
- Priority in a single cycle: stop > sfx_req > start.
  - stop from any state → IDLE next cycle; no done, no sfx_ack; resume flag cleared.
  - sfx_req+start together → SFX; afterwards NOTE at index 0 (resume flag set, note_idx forced to 0).
  - start while in NOTE/GAP → restart at index 0.
  - start while in SFX → ignored.
- loop_en is sampled only at the end of GAP.
- Arithmetic:
  - 32-bit unsigned counter. Max beats 15 → 15*BEAT_CYCLES must fit in 32 bits.
  - The note-length product is computed with a 32-bit width; no truncation.
  - beats*BEAT_CYCLES ≤ GAP_CYCLES is illegal (assert in simulation).
- note_idx wraps only via the loop rule; it never increments past SONG_LEN-1.

Decomposition:
- Package tone_pkg:
  - state enum (IDLE, NOTE, GAP, SFX);
  - ROM entry field widths and offsets;
  - END_MARKER=4'd0;
  - DIV_W=27.
- Sub-module melody_rom: combinational lookup, index → entry. Contents come from the package, with a parameter override so benches can load short songs.

Test Plan (BEAT_CYCLES=10, GAP_CYCLES=2, SFX_CYCLES=5, test ROM: e0={L=100,R=200,b=1}, e1={L=300,R=400,b=2}, e2=end):
- start pulse, loop_en=0 → e0 divs unmuted 8 cycles, muted 2; e1 unmuted 18, muted 2; then IDLE, done=1 for 1 cycle, busy falls the same cycle.
- Same with loop_en=1 → after e1's gap, note_idx=0 and divs=100/200; no done pulse.
- sfx_req on cycle 4 of e1 → next cycle divs=SFX_DIV, mute=0 for 5 cycles; sfx_ack pulse; then e1 replays from its start (18 unmuted cycles).
- sfx_req in IDLE → 5 SFX cycles, sfx_ack, return to IDLE with mute=1, busy=0.
- stop during SFX → IDLE next cycle, no sfx_ack. stop+start in the same cycle → stays IDLE.
- rst asserted mid-NOTE (async, between edges) → outputs reset values immediately. After release, no activity until start.

Source files
------------

// File: rtl/tone_pkg.sv
// -----------------------------------------------------------------------------
// tone_pkg
// Shared types and constants for the tone sequencer: the FSM state encoding,
// the melody ROM entry layout and the default song image.
// -----------------------------------------------------------------------------
package tone_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NOTE = 2'd1,
        GAP  = 2'd2,
        SFX  = 2'd3
    } state_t;

    localparam int DIV_W            = 27;
    localparam int BEATS_W          = 4;
    localparam int CNT_W            = 32;
    localparam int ENTRY_W          = 2 * DIV_W + BEATS_W;
    localparam int BEATS_OFF        = 0;
    localparam int RIGHT_OFF        = BEATS_OFF + BEATS_W;
    localparam int LEFT_OFF         = RIGHT_OFF + DIV_W;
    localparam int DEFAULT_SONG_LEN = 32;

    localparam logic [BEATS_W-1:0] END_MARKER = 4'd0;

    // ROM entry: {left_div, right_div, beats}, beats == END_MARKER ends the song
    typedef struct packed {
        logic [DIV_W-1:0]   left_div;
        logic [DIV_W-1:0]   right_div;
        logic [BEATS_W-1:0] beats;
    } rom_entry_t;

    function automatic rom_entry_t make_entry(input int unsigned l,
                                              input int unsigned r,
                                              input int unsigned b);
        rom_entry_t e;
        e.left_div  = DIV_W'(l);
        e.right_div = DIV_W'(r);
        e.beats     = BEATS_W'(b);
        return e;
    endfunction

    // Short C-major phrase, right channel an octave below; unused slots are end markers
    function automatic logic [DEFAULT_SONG_LEN*ENTRY_W-1:0] default_song();
        logic [DEFAULT_SONG_LEN*ENTRY_W-1:0] s;
        s = '0;
        s[0*ENTRY_W +: ENTRY_W] = make_entry(32'd191113, 32'd382226, 32'd2);
        s[1*ENTRY_W +: ENTRY_W] = make_entry(32'd151745, 32'd303490, 32'd2);
        s[2*ENTRY_W +: ENTRY_W] = make_entry(32'd127551, 32'd255102, 32'd2);
        s[3*ENTRY_W +: ENTRY_W] = make_entry(32'd95511,  32'd191113, 32'd4);
        s[4*ENTRY_W +: ENTRY_W] = make_entry(32'd127551, 32'd255102, 32'd1);
        s[5*ENTRY_W +: ENTRY_W] = make_entry(32'd151745, 32'd303490, 32'd1);
        s[6*ENTRY_W +: ENTRY_W] = make_entry(32'd191113, 32'd382226, 32'd4);
        return s;
    endfunction

    localparam logic [DEFAULT_SONG_LEN*ENTRY_W-1:0] DEFAULT_SONG = default_song();

endpackage

// File: rtl/melody_rom.sv
// -----------------------------------------------------------------------------
// melody_rom
// Combinational song store with two read ports.
//   i_idx      : full-entry read index
//   o_entry    : {left_div, right_div, beats} at i_idx
//   i_peek_idx : look-ahead index
//   o_peek_beats : beats field at i_peek_idx (end-of-song detection)
// Out-of-range indices read as an end marker.
// -----------------------------------------------------------------------------
module melody_rom
    import tone_pkg::*;
#(
    parameter int unsigned                        SONG_LEN = DEFAULT_SONG_LEN,
    parameter int                                 IDX_W    = $clog2(SONG_LEN),
    parameter logic [SONG_LEN*ENTRY_W-1:0]        ROM_INIT = DEFAULT_SONG
) (
    input  logic [IDX_W-1:0]   i_idx,
    output rom_entry_t         o_entry,
    input  logic [IDX_W-1:0]   i_peek_idx,
    output logic [BEATS_W-1:0] o_peek_beats
);

    rom_entry_t w_peek_entry;

    // Full-entry read port
    always_comb begin
        o_entry = '0;
        if (32'(i_idx) < SONG_LEN) begin
            o_entry = ROM_INIT[32'(i_idx)*ENTRY_W +: ENTRY_W];
        end else begin
            o_entry = '0;
        end
    end

    // Look-ahead read port, beats only
    always_comb begin
        w_peek_entry = '0;
        if (32'(i_peek_idx) < SONG_LEN) begin
            w_peek_entry = ROM_INIT[32'(i_peek_idx)*ENTRY_W +: ENTRY_W];
        end else begin
            w_peek_entry = '0;
        end
    end

    assign o_peek_beats = w_peek_entry.beats;

endmodule

// File: rtl/tone_sequencer_chk.sv
// -----------------------------------------------------------------------------
// tone_sequencer_chk
// Simulation checker: every note entered must be longer than the articulation
// gap, otherwise the note phase would have zero or negative length.
//   i_enter_note : sequencer will be in NOTE next cycle
//   i_full_len   : beats * BEAT_CYCLES of that note
// -----------------------------------------------------------------------------
module tone_sequencer_chk #(
    parameter int unsigned GAP_CYCLES = 32'd2_500_000
) (
    input logic        clk,
    input logic        rst,
    input logic        i_enter_note,
    input logic [31:0] i_full_len
);

    // Note length must exceed the gap
    a_note_len: assert property (@(posedge clk) disable iff (!rst)
        i_enter_note |-> (i_full_len > GAP_CYCLES));

endmodule

// File: rtl/tone_sequencer.sv
// -----------------------------------------------------------------------------
// tone_sequencer
// Plays a stored two-channel melody into the stereo buzzer at a fixed tempo,
// with a pre-empting one-shot sound effect and a mute flag.
//   clk, rst (async, active low)
//   start, stop, sfx_req : single-cycle command pulses (stop > sfx_req > start)
//   loop_en              : wrap to entry 0 at song end
//   right_div, left_div  : buzzer dividers
//   mute                 : silence buzzer
//   busy                 : not idle
//   done, sfx_ack        : one-cycle completion pulses
//   note_idx             : current ROM index
// All outputs are registered; next-state and next-output values are computed
// together so a command sampled in cycle N is visible in cycle N+1.
// -----------------------------------------------------------------------------
module tone_sequencer
    import tone_pkg::*;
#(
    parameter int unsigned                 BEAT_CYCLES = 32'd25_000_000,
    parameter int unsigned                 GAP_CYCLES  = 32'd2_500_000,
    parameter int unsigned                 SFX_CYCLES  = 32'd10_000_000,
    parameter logic [DIV_W-1:0]            SFX_DIV     = 27'd50_000,
    parameter int unsigned                 SONG_LEN    = DEFAULT_SONG_LEN,
    parameter int                          IDX_W       = $clog2(SONG_LEN),
    parameter logic [SONG_LEN*ENTRY_W-1:0] ROM_INIT    = DEFAULT_SONG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
    input  logic             sfx_req,
    output logic [DIV_W-1:0] right_div,
    output logic [DIV_W-1:0] left_div,
    output logic             mute,
    output logic             busy,
    output logic             done,
    output logic             sfx_ack,
    output logic [IDX_W-1:0] note_idx
);

    localparam logic [CNT_W-1:0] GAP_LAST  = 32'(GAP_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] SFX_LAST  = 32'(SFX_CYCLES - 32'd1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(SONG_LEN - 32'd1);
    localparam logic [IDX_W-1:0] IDX_ZERO  = '0;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_note_len;
    logic [IDX_W-1:0] r_note_idx;
    logic             r_resume;
    logic [DIV_W-1:0] r_right_div;
    logic [DIV_W-1:0] r_left_div;
    logic             r_mute;
    logic             r_busy;
    logic             r_done;
    logic             r_sfx_ack;

    state_t           w_nxt_state;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic [CNT_W-1:0] w_nxt_note_len;
    logic [IDX_W-1:0] w_nxt_idx;
    logic             w_nxt_resume;
    logic [DIV_W-1:0] w_nxt_right;
    logic [DIV_W-1:0] w_nxt_left;
    logic             w_nxt_mute;
    logic             w_nxt_done;
    logic             w_nxt_ack;
    logic [IDX_W-1:0] w_idx_inc;
    logic             w_at_end;
    rom_entry_t       w_rd_entry;
    logic [BEATS_W-1:0] w_peek_beats;
    logic [CNT_W-1:0] w_full_len;

    melody_rom #(
        .SONG_LEN (SONG_LEN),
        .IDX_W    (IDX_W),
        .ROM_INIT (ROM_INIT)
    ) u_rom (
        .i_idx        (w_nxt_idx),
        .o_entry      (w_rd_entry),
        .i_peek_idx   (w_idx_inc),
        .o_peek_beats (w_peek_beats)
    );

    // Index never runs past the last ROM slot; wrap happens only via the loop rule
    assign w_idx_inc  = (r_note_idx == IDX_LAST) ? r_note_idx : (r_note_idx + 1'b1);
    assign w_at_end   = (r_note_idx == IDX_LAST) || (w_peek_beats == END_MARKER);
    assign w_full_len = 32'(w_rd_entry.beats) * 32'(BEAT_CYCLES);

    // Next-state, index, counter and pulse logic
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_idx    = r_note_idx;
        w_nxt_cnt    = r_cnt + 32'd1;
        w_nxt_resume = r_resume;
        w_nxt_done   = 1'b0;
        w_nxt_ack    = 1'b0;
        if (stop) begin
            w_nxt_state  = IDLE;
            w_nxt_idx    = IDX_ZERO;
            w_nxt_cnt    = 32'd0;
            w_nxt_resume = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_nxt_cnt = 32'd0;
                    if (sfx_req) begin
                        // start alongside sfx_req queues a fresh playback after the effect
                        w_nxt_state  = SFX;
                        w_nxt_resume = start;
                        w_nxt_idx    = start ? IDX_ZERO : r_note_idx;
                    end else if (start) begin
                        w_nxt_state = NOTE;
                        w_nxt_idx   = IDX_ZERO;
                    end else begin
                        w_nxt_state = IDLE;
                    end
                end
                NOTE, GAP: begin
                    if (sfx_req) begin
                        w_nxt_state  = SFX;
                        w_nxt_cnt    = 32'd0;
                        w_nxt_resume = 1'b1;
                        w_nxt_idx    = start ? IDX_ZERO : r_note_idx;
                    end else if (start) begin
                        w_nxt_state = NOTE;
                        w_nxt_idx   = IDX_ZERO;
                        w_nxt_cnt   = 32'd0;
                    end else if (r_state == NOTE) begin
                        if (r_cnt == (r_note_len - 32'd1)) begin
                            w_nxt_state = GAP;
                            w_nxt_cnt   = 32'd0;
                        end else begin
                            w_nxt_state = NOTE;
                        end
                    end else if (r_cnt == GAP_LAST) begin
                        w_nxt_cnt = 32'd0;
                        if (!w_at_end) begin
                            w_nxt_state = NOTE;
                            w_nxt_idx   = w_idx_inc;
                        end else if (loop_en) begin
                            w_nxt_state = NOTE;
                            w_nxt_idx   = IDX_ZERO;
                        end else begin
                            w_nxt_state = IDLE;
                            w_nxt_idx   = IDX_ZERO;
                            w_nxt_done  = 1'b1;
                        end
                    end else begin
                        w_nxt_state = GAP;
                    end
                end
                SFX: begin
                    // start and sfx_req are ignored while the effect plays
                    if (r_cnt == SFX_LAST) begin
                        w_nxt_cnt    = 32'd0;
                        w_nxt_ack    = 1'b1;
                        w_nxt_resume = 1'b0;
                        w_nxt_state  = r_resume ? NOTE : IDLE;
                    end else begin
                        w_nxt_state = SFX;
                    end
                end
                default: begin
                    w_nxt_state  = IDLE;
                    w_nxt_idx    = IDX_ZERO;
                    w_nxt_cnt    = 32'd0;
                    w_nxt_resume = 1'b0;
                end
            endcase
        end
    end

    // Output values for the state being entered
    always_comb begin
        w_nxt_right    = '0;
        w_nxt_left     = '0;
        w_nxt_mute     = 1'b1;
        w_nxt_note_len = r_note_len;
        case (w_nxt_state)
            IDLE: begin
                w_nxt_mute = 1'b1;
            end
            NOTE: begin
                w_nxt_right    = w_rd_entry.right_div;
                w_nxt_left     = w_rd_entry.left_div;
                w_nxt_mute     = 1'b0;
                w_nxt_note_len = w_full_len - 32'(GAP_CYCLES);
            end
            GAP: begin
                w_nxt_right = r_right_div;
                w_nxt_left  = r_left_div;
                w_nxt_mute  = 1'b1;
            end
            SFX: begin
                w_nxt_right = SFX_DIV;
                w_nxt_left  = SFX_DIV;
                w_nxt_mute  = 1'b0;
            end
            default: begin
                w_nxt_mute = 1'b1;
            end
        endcase
    end

    // State, counter and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= 32'd0;
            r_note_len  <= 32'd0;
            r_note_idx  <= IDX_ZERO;
            r_resume    <= 1'b0;
            r_right_div <= '0;
            r_left_div  <= '0;
            r_mute      <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_sfx_ack   <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_cnt       <= w_nxt_cnt;
            r_note_len  <= w_nxt_note_len;
            r_note_idx  <= w_nxt_idx;
            r_resume    <= w_nxt_resume;
            r_right_div <= w_nxt_right;
            r_left_div  <= w_nxt_left;
            r_mute      <= w_nxt_mute;
            r_busy      <= (w_nxt_state != IDLE);
            r_done      <= w_nxt_done;
            r_sfx_ack   <= w_nxt_ack;
        end
    end

    assign right_div = r_right_div;
    assign left_div  = r_left_div;
    assign mute      = r_mute;
    assign busy      = r_busy;
    assign done      = r_done;
    assign sfx_ack   = r_sfx_ack;
    assign note_idx  = r_note_idx;

    tone_sequencer_chk #(
        .GAP_CYCLES (GAP_CYCLES)
    ) u_chk (
        .clk          (clk),
        .rst          (rst),
        .i_enter_note (w_nxt_state == NOTE),
        .i_full_len   (w_full_len)
    );

endmodule

// File: tb/tb_tone_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tone_sequencer
// Directed bench for tone_sequencer with a 3-entry song (two notes + end).
// -----------------------------------------------------------------------------
module tb_tone_sequencer;
    import tone_pkg::*;

    localparam int IDX_W = 2;
    localparam logic [4*ENTRY_W-1:0] TB_ROM = {
        58'd0,
        58'd0,
        {27'd300, 27'd400, 4'd2},
        {27'd100, 27'd200, 4'd1}
    };

    logic             clk;
    logic             rst;
    logic             start;
    logic             stop;
    logic             loop_en;
    logic             sfx_req;
    logic [DIV_W-1:0] right_div;
    logic [DIV_W-1:0] left_div;
    logic             mute;
    logic             busy;
    logic             done;
    logic             sfx_ack;
    logic [IDX_W-1:0] note_idx;

    int n_checks;
    int n_errors;

    tone_sequencer #(
        .BEAT_CYCLES (32'd10),
        .GAP_CYCLES  (32'd2),
        .SFX_CYCLES  (32'd5),
        .SFX_DIV     (27'd50_000),
        .SONG_LEN    (32'd4),
        .IDX_W       (IDX_W),
        .ROM_INIT    (TB_ROM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .loop_en   (loop_en),
        .sfx_req   (sfx_req),
        .right_div (right_div),
        .left_div  (left_div),
        .mute      (mute),
        .busy      (busy),
        .done      (done),
        .sfx_ack   (sfx_ack),
        .note_idx  (note_idx)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance to 1 ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check n consecutive cycles of a phase, leaving the bench at the next phase
    task automatic run(input string tag, input int n, input logic m,
                       input int l, input int r, input int idx, input logic b);
        for (int i = 0; i < n; i++) begin
            check({tag, ".mute"},  32'(mute), 32'(m));
            check({tag, ".left"},  32'(left_div), 32'(l));
            check({tag, ".right"}, 32'(right_div), 32'(r));
            check({tag, ".idx"},   32'(note_idx), 32'(idx));
            check({tag, ".busy"},  32'(busy), 32'(b));
            check({tag, ".done"},  32'(done), 32'd0);
            tick();
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".mute"},  32'(mute), 32'd1);
        check({tag, ".busy"},  32'(busy), 32'd0);
        check({tag, ".left"},  32'(left_div), 32'd0);
        check({tag, ".right"}, 32'(right_div), 32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        start    = 1'b0;
        stop     = 1'b0;
        loop_en  = 1'b0;
        sfx_req  = 1'b0;
        rst      = 1'b0;
        #13;
        // reset state
        check_idle("reset");
        check("reset.idx",  32'(note_idx), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.ack",  32'(sfx_ack), 32'd0);
        rst = 1'b1;
        tick();
        tick();
        check_idle("post_reset");

        // song once, no loop: 8/2, 18/2, then done
        pulse_start();
        run("e0_note", 8, 1'b0, 100, 200, 0, 1'b1);
        run("e0_gap",  2, 1'b1, 100, 200, 0, 1'b1);
        run("e1_note", 18, 1'b0, 300, 400, 1, 1'b1);
        run("e1_gap",  2, 1'b1, 300, 400, 1, 1'b1);
        check_idle("end");
        check("end.done", 32'(done), 32'd1);
        tick();
        check("end.done_1cyc", 32'(done), 32'd0);
        check_idle("end_after");

        // looping: back to entry 0 with no done
        loop_en = 1'b1;
        pulse_start();
        run("l_e0_note", 8, 1'b0, 100, 200, 0, 1'b1);
        run("l_e0_gap",  2, 1'b1, 100, 200, 0, 1'b1);
        run("l_e1_note", 18, 1'b0, 300, 400, 1, 1'b1);
        run("l_e1_gap",  2, 1'b1, 300, 400, 1, 1'b1);
        check("loop.idx",   32'(note_idx), 32'd0);
        check("loop.left",  32'(left_div), 32'd100);
        check("loop.right", 32'(right_div), 32'd200);
        check("loop.mute",  32'(mute), 32'd0);
        check("loop.done",  32'(done), 32'd0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        loop_en = 1'b0;
        check_idle("loop_stop");

        // SFX pre-empting e1 on its 5th cycle, then e1 replays from its start
        pulse_start();
        run("s_e0_note", 8, 1'b0, 100, 200, 0, 1'b1);
        run("s_e0_gap",  2, 1'b1, 100, 200, 0, 1'b1);
        run("s_e1_pre",  4, 1'b0, 300, 400, 1, 1'b1);
        sfx_req = 1'b1;
        tick();
        sfx_req = 1'b0;
        run("sfx_a", 1, 1'b0, 50000, 50000, 1, 1'b1);
        sfx_req = 1'b1;
        run("sfx_b", 1, 1'b0, 50000, 50000, 1, 1'b1);
        sfx_req = 1'b0;
        check("sfx.no_early_ack", 32'(sfx_ack), 32'd0);
        run("sfx_c", 3, 1'b0, 50000, 50000, 1, 1'b1);
        check("sfx.ack", 32'(sfx_ack), 32'd1);
        run("s_e1_replay", 18, 1'b0, 300, 400, 1, 1'b1);
        check("sfx.ack_1cyc", 32'(sfx_ack), 32'd0);
        run("s_e1_gap", 2, 1'b1, 300, 400, 1, 1'b1);
        check("sfx_song.done", 32'(done), 32'd1);
        tick();

        // SFX from IDLE returns to IDLE
        sfx_req = 1'b1;
        tick();
        sfx_req = 1'b0;
        run("idle_sfx", 5, 1'b0, 50000, 50000, 0, 1'b1);
        check("idle_sfx.ack", 32'(sfx_ack), 32'd1);
        check_idle("idle_sfx_ret");
        tick();
        check("idle_sfx.ack_1cyc", 32'(sfx_ack), 32'd0);

        // stop during SFX: immediate idle, no ack
        sfx_req = 1'b1;
        tick();
        sfx_req = 1'b0;
        run("stop_sfx", 2, 1'b0, 50000, 50000, 0, 1'b1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_idle("stop_sfx");
        check("stop_sfx.ack", 32'(sfx_ack), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stop_sfx.late_ack", 32'(sfx_ack), 32'd0);
        end

        // stop wins over start
        stop  = 1'b1;
        start = 1'b1;
        tick();
        stop  = 1'b0;
        start = 1'b0;
        check_idle("stop_start");
        tick();
        check_idle("stop_start2");

        // async reset in the middle of a note
        pulse_start();
        run("rst_note", 3, 1'b0, 100, 200, 0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check_idle("async_rst");
        check("async_rst.idx", 32'(note_idx), 32'd0);
        #3;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_idle("after_rst");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
